// File: rtl/fp_normalize_pack_pkg.sv
// Shared floating-point definitions: IEEE-754 single layout, special encodings and
// the state encoding of the normalize/round/pack engine.
package floatingpoint;

    localparam int          EXPONENT_BIAS = 127;
    localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF    = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        OUT
    } fpnp_state_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } fp32_t;

endpackage

// File: rtl/fp_normalize_pack_round.sv
// Round-to-nearest-even on a 23-bit fraction; carry flags a wrap to the next binade.
module fp_round_rne (
    input  logic [22:0] frac,
    input  logic        guard,
    input  logic        sticky,
    output logic [22:0] frac_rnd,
    output logic        carry
);

    logic inc;

    // Ties (guard set, nothing below it) go up only when the kept LSB is odd.
    assign inc              = guard & (sticky | frac[0]);
    assign {carry, frac_rnd} = {1'b0, frac} + {23'd0, inc};

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalizes a raw sign/exponent/wide-mantissa result one shift per cycle, rounds RNE
// and packs it as IEEE-754 single. Single entry, valid/ready on both sides.
module fp_normalize_pack
    import floatingpoint::*;
#(
    parameter int MANT_IN_W = 48,
    parameter int EXP_IN_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_IN_W-1:0]  in_exp,
    input  logic [MANT_IN_W-1:0] in_mant,
    input  logic                 in_nan,
    input  logic                 in_inf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_float,
    output logic                 out_ovf,
    output logic                 out_unf
);

    // Handshake: a transfer happens on any rising edge where valid && ready; the
    // producer holds its payload stable while valid is high and ready is low.

    localparam int MW = MANT_IN_W;
    localparam int EW = EXP_IN_W + 2;

    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 * EXPONENT_BIAS + 1);

    fpnp_state_e state, next_state;

    logic                 sign_r;
    logic signed [EW-1:0] exp_r;
    logic [MW-1:0]        mant_r;
    fp32_t                res_r;
    logic                 ovf_r;
    logic                 unf_r;

    logic                 special_in;
    logic [22:0]          frac_w;
    logic [22:0]          frac_rnd;
    logic                 guard_w;
    logic                 sticky_w;
    logic                 carry_w;
    logic signed [EW-1:0] exp_rnd;

    assign special_in = in_nan | in_inf | (in_mant == '0);

    assign frac_w   = mant_r[MW-3:MW-25];
    assign guard_w  = mant_r[MW-26];
    assign sticky_w = |mant_r[MW-27:0];

    fp_round_rne u_round (
        .frac     (frac_w),
        .guard    (guard_w),
        .sticky   (sticky_w),
        .frac_rnd (frac_rnd),
        .carry    (carry_w)
    );

    assign exp_rnd = exp_r + (carry_w ? EXP_ONE : EXP_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = special_in ? OUT : NORM;
            NORM:    if (!mant_r[MW-1] && mant_r[MW-2]) next_state = ROUND;
            ROUND:   next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            res_r  <= '0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_sign;
                        exp_r  <= {{2{in_exp[EXP_IN_W-1]}}, in_exp};
                        mant_r <= in_mant;
                        if (in_nan) begin
                            res_r <= fp32_t'(FP_QNAN);
                        end else if (in_inf) begin
                            res_r <= fp32_t'(FP_POS_INF | {in_sign, 31'h0});
                        end else if (in_mant == '0) begin
                            res_r <= fp32_t'({in_sign, 31'h0});
                        end
                    end
                end
                NORM: begin
                    // Right shift keeps the dropped bit alive as sticky in bit 0.
                    if (mant_r[MW-1]) begin
                        mant_r <= {1'b0, mant_r[MW-1:2], mant_r[1] | mant_r[0]};
                        exp_r  <= exp_r + EXP_ONE;
                    end else if (!mant_r[MW-2]) begin
                        mant_r <= {mant_r[MW-2:0], 1'b0};
                        exp_r  <= exp_r - EXP_ONE;
                    end
                end
                ROUND: begin
                    if (exp_rnd >= EXP_MAX) begin
                        res_r <= fp32_t'(FP_POS_INF | {sign_r, 31'h0});
                        ovf_r <= 1'b1;
                    end else if (exp_rnd <= EXP_ZERO) begin
                        res_r <= fp32_t'({sign_r, 31'h0});
                        unf_r <= 1'b1;
                    end else begin
                        res_r.sign     <= sign_r;
                        res_r.exponent <= exp_rnd[7:0];
                        res_r.fraction <= frac_rnd;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_float = res_r;
    assign out_ovf   = ovf_r;
    assign out_unf   = unf_r;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed-vector bench for fp_normalize_pack: normalization, RNE rounding, range limits,
// special operands, output back-pressure and reset in the middle of an operation.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_ovf;
    logic        out_unf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        nan;
        logic        inf;
        logic [31:0] res;
        logic [1:0]  flags;
        int          waits;
        string       name;
    } vec_t;

    fp_normalize_pack #(.MANT_IN_W(48), .EXP_IN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [47:0] m,
                                input logic nan, input logic inf, input logic [31:0] res,
                                input logic [1:0] flags, input int waits, input string name);
        vec_t v;
        v.sign = s; v.exp = e; v.mant = m; v.nan = nan; v.inf = inf;
        v.res = res; v.flags = flags; v.waits = waits; v.name = name;
        return v;
    endfunction

    // Drives one operand, counts the extra cycles after the accepting edge until
    // out_valid, captures the result, accepts it and samples the state one cycle later.
    task automatic drive_op(input vec_t v, output logic [31:0] f, output logic [1:0] fl,
                            output int waits, output logic [3:0] post);
        @(negedge clk);
        in_valid = 1'b1; in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
        in_nan = v.nan; in_inf = v.inf;
        @(negedge clk);
        in_valid = 1'b0; in_nan = 1'b0; in_inf = 1'b0;
        waits = 0;
        while (!out_valid && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        f  = out_float;
        fl = {out_ovf, out_unf};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        post = {in_ready, out_valid, out_ovf, out_unf};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b0;
        #3;
        total_cnt++;
        if ({in_ready, out_valid, out_float, out_ovf, out_unf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0})
            $display("FAIL reset_outputs got rdy=%b vld=%b f=%08h ovf=%b unf=%b want 1 0 00000000 0 0",
                     in_ready, out_valid, out_float, out_ovf, out_unf);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normalize();
        vec_t v[$];
        logic [31:0] f; logic [1:0] fl; int w; logic [3:0] post;
        v.push_back(mk(1'b0, 10'd127, 48'd1 << 46, 1'b0, 1'b0, 32'h3F80_0000, 2'b00, 2, "one"));
        // 3.0 carries the integer bit at position 47 and needs one right shift.
        v.push_back(mk(1'b0, 10'd127, 48'd3 << 46, 1'b0, 1'b0, 32'h4040_0000, 2'b00, 3, "three"));
        v.push_back(mk(1'b0, 10'd127, 48'd1 << 40, 1'b0, 1'b0, 32'h3C80_0000, 2'b00, 8, "left6"));
        v.push_back(mk(1'b1, 10'd127, 48'd1 << 46, 1'b0, 1'b0, 32'hBF80_0000, 2'b00, 2, "neg_one"));
        foreach (v[i]) begin
            drive_op(v[i], f, fl, w, post);
            total_cnt++;
            if (f !== v[i].res) $display("FAIL %s float got %08h want %08h", v[i].name, f, v[i].res);
            else pass_cnt++;
            total_cnt++;
            if (fl !== v[i].flags) $display("FAIL %s flags got %b want %b", v[i].name, fl, v[i].flags);
            else pass_cnt++;
            total_cnt++;
            if (w !== v[i].waits) $display("FAIL %s latency got %0d want %0d", v[i].name, w, v[i].waits);
            else pass_cnt++;
        end
        total_cnt++;
        if (post !== 4'b1000) $display("FAIL norm_post_accept got %b want 1000", post);
        else pass_cnt++;
    endtask

    task automatic test_rounding();
        vec_t v[$];
        logic [31:0] f; logic [1:0] fl; int w; logic [3:0] post;
        v.push_back(mk(1'b0, 10'd127, (48'd1 << 46) | (48'd1 << 22), 1'b0, 1'b0, 32'h3F80_0000, 2'b00, 2, "tie_even"));
        v.push_back(mk(1'b0, 10'd127, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22), 1'b0, 1'b0, 32'h3F80_0002, 2'b00, 2, "tie_odd"));
        v.push_back(mk(1'b0, 10'd127, (48'd1 << 46) | (48'd1 << 22) | 48'd1, 1'b0, 1'b0, 32'h3F80_0001, 2'b00, 2, "above_half"));
        v.push_back(mk(1'b0, 10'd127, (48'd1 << 47) - 48'd1, 1'b0, 1'b0, 32'h4000_0000, 2'b00, 2, "carry_exp"));
        // The bit shifted out on the right turns a tie into round-up.
        v.push_back(mk(1'b0, 10'd127, (48'd1 << 47) | (48'd1 << 23) | 48'd1, 1'b0, 1'b0, 32'h4000_0001, 2'b00, 3, "shift_sticky"));
        foreach (v[i]) begin
            drive_op(v[i], f, fl, w, post);
            total_cnt++;
            if (f !== v[i].res) $display("FAIL %s float got %08h want %08h", v[i].name, f, v[i].res);
            else pass_cnt++;
            total_cnt++;
            if (w !== v[i].waits) $display("FAIL %s latency got %0d want %0d", v[i].name, w, v[i].waits);
            else pass_cnt++;
        end
    endtask

    task automatic test_ovf_unf();
        vec_t v[$];
        logic [31:0] f; logic [1:0] fl; int w; logic [3:0] post;
        v.push_back(mk(1'b0, 10'd254, (48'd1 << 47) - 48'd1, 1'b0, 1'b0, 32'h7F80_0000, 2'b10, 2, "ovf_round"));
        v.push_back(mk(1'b1, 10'd300, 48'd1 << 46, 1'b0, 1'b0, 32'hFF80_0000, 2'b10, 2, "ovf_big"));
        v.push_back(mk(1'b0, 10'd254, 48'd1 << 46, 1'b0, 1'b0, 32'h7F00_0000, 2'b00, 2, "max_exp"));
        v.push_back(mk(1'b1, 10'd1, 48'd1 << 45, 1'b0, 1'b0, 32'h8000_0000, 2'b01, 3, "unf_shift"));
        v.push_back(mk(1'b0, 10'h3FD, 48'd1 << 46, 1'b0, 1'b0, 32'h0000_0000, 2'b01, 2, "unf_neg"));
        v.push_back(mk(1'b0, 10'd1, 48'd1 << 46, 1'b0, 1'b0, 32'h0080_0000, 2'b00, 2, "min_exp"));
        foreach (v[i]) begin
            drive_op(v[i], f, fl, w, post);
            total_cnt++;
            if (f !== v[i].res) $display("FAIL %s float got %08h want %08h", v[i].name, f, v[i].res);
            else pass_cnt++;
            total_cnt++;
            if (fl !== v[i].flags) $display("FAIL %s flags got %b want %b", v[i].name, fl, v[i].flags);
            else pass_cnt++;
            total_cnt++;
            if (post !== 4'b1000) $display("FAIL %s post_accept got %b want 1000", v[i].name, post);
            else pass_cnt++;
        end
    endtask

    task automatic test_specials();
        vec_t v[$];
        logic [31:0] f; logic [1:0] fl; int w; logic [3:0] post;
        v.push_back(mk(1'b1, 10'd127, 48'd1 << 46, 1'b1, 1'b0, 32'h7FC0_0000, 2'b00, 0, "nan"));
        v.push_back(mk(1'b0, 10'd5, 48'd0, 1'b1, 1'b1, 32'h7FC0_0000, 2'b00, 0, "nan_inf"));
        v.push_back(mk(1'b1, 10'd127, 48'd1 << 46, 1'b0, 1'b1, 32'hFF80_0000, 2'b00, 0, "inf_neg"));
        v.push_back(mk(1'b1, 10'd127, 48'd0, 1'b0, 1'b0, 32'h8000_0000, 2'b00, 0, "zero_neg"));
        foreach (v[i]) begin
            drive_op(v[i], f, fl, w, post);
            total_cnt++;
            if (f !== v[i].res) $display("FAIL %s float got %08h want %08h", v[i].name, f, v[i].res);
            else pass_cnt++;
            total_cnt++;
            if ({fl, w} !== {v[i].flags, v[i].waits})
                $display("FAIL %s flags/latency got %b/%0d want %b/%0d", v[i].name, fl, w, v[i].flags, v[i].waits);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int bad;
        // Overflow result held under back-pressure while new input is offered.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd254; in_mant = (48'd1 << 47) - 48'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({out_valid, in_ready, out_float, out_ovf, out_unf} !== {1'b1, 1'b0, 32'h7F80_0000, 1'b1, 1'b0})
                bad++;
            in_valid = 1'b1; in_nan = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (bad != 0) $display("FAIL hold_stable got %0d unstable cycles want 0 (f=%08h)", bad, out_float);
        else pass_cnt++;
        in_valid = 1'b0; in_nan = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, out_ovf} !== 3'b100)
            $display("FAIL hold_release got %b want 100", {in_ready, out_valid, out_ovf});
        else pass_cnt++;
        // Busy block must ignore a different operand offered during NORM.
        @(negedge clk);
        in_valid = 1'b1; in_exp = 10'd127; in_mant = 48'd1 << 40;
        @(negedge clk);
        in_inf = 1'b1; in_mant = 48'd1 << 46;
        repeat (3) @(negedge clk);
        in_valid = 1'b0; in_inf = 1'b0;
        bad = 0;
        while (!out_valid && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        total_cnt++;
        if (out_float !== 32'h3C80_0000) $display("FAIL busy_ignore float got %08h want 3c800000", out_float);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        vec_t v;
        logic [31:0] f; logic [1:0] fl; int w; logic [3:0] post;
        int seen;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_mant = 48'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b00) $display("FAIL mid_busy got %b want 00", {in_ready, out_valid});
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, out_float} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL mid_reset got rdy=%b vld=%b f=%08h want 1 0 00000000", in_ready, out_valid, out_float);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL mid_no_output got %0d valid cycles want 0", seen);
        else pass_cnt++;
        v = mk(1'b0, 10'd127, 48'd3 << 46, 1'b0, 1'b0, 32'h4040_0000, 2'b00, 3, "after_reset");
        drive_op(v, f, fl, w, post);
        total_cnt++;
        if ({f, w} !== {v.res, v.waits})
            $display("FAIL after_reset got %08h/%0d want %08h/%0d", f, w, v.res, v.waits);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_rounding();
        test_ovf_unf();
        test_specials();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
